// File: rtl/alu_pkg.sv
// Shared constants for the adder result stage: flag bit positions, buffer depth
// and the per-bit saturation patterns that are scaled to any datapath width.
package alu_pkg;

    localparam int DEPTH_C = 2;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Saturation value = {MSB, {WIDTH-1{FILL}}}
    localparam logic SAT_POS_MSB  = 1'b0;
    localparam logic SAT_POS_FILL = 1'b1;
    localparam logic SAT_NEG_MSB  = 1'b1;
    localparam logic SAT_NEG_FILL = 1'b0;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/adder_result_stage_if.sv
// Upstream adder / downstream consumer bundle for adder_result_stage.
// master = environment side, slave = the result stage.
interface adder_result_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             a_msb;
    logic             b_msb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic [15:0]      op_count;

    modport master (
        output in_valid, s, cout, a_msb, b_msb, out_ready,
        input  in_ready, out_valid, result, flags, op_count
    );

    modport slave (
        input  in_valid, s, cout, a_msb, b_msb, out_ready,
        output in_ready, out_valid, result, flags, op_count
    );
endinterface

// File: rtl/adder_result_stage_nzcv_calc.sv
// Combinational NZCV flag generation and optional saturation of the stored value.
// Saturation on signed overflow is enabled by defining RESULT_SAT_EN.
module nzcv_calc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] s_i,
    input  logic             cout_i,
    input  logic             a_msb_i,
    input  logic             b_msb_i,
    output logic [WIDTH-1:0] result_o,
    output flags_t           flags_o
);

    logic             v_s;
    logic [WIDTH-1:0] res_s;

    assign v_s = (a_msb_i == b_msb_i) && (s_i[WIDTH-1] != a_msb_i);

    // Select stored value; N and Z follow it, C and V follow the raw adder outputs
    always_comb begin
        res_s = s_i;
`ifdef RESULT_SAT_EN
        if (v_s) begin
            if (a_msb_i) begin
                res_s = {SAT_NEG_MSB, {(WIDTH-1){SAT_NEG_FILL}}};
            end else begin
                res_s = {SAT_POS_MSB, {(WIDTH-1){SAT_POS_FILL}}};
            end
        end else begin
            res_s = s_i;
        end
`endif
        flags_o         = 4'b0000;
        flags_o[FLAG_N] = res_s[WIDTH-1];
        flags_o[FLAG_Z] = (res_s == {WIDTH{1'b0}});
        flags_o[FLAG_C] = cout_i;
        flags_o[FLAG_V] = v_s;
    end

    assign result_o = res_s;

endmodule

// File: rtl/adder_result_stage.sv
// Two-entry result buffer behind a full adder, tagging each sum with NZCV flags.
// Optional saturation of overflowed sums is enabled by defining RESULT_SAT_EN.
module adder_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = DEPTH_C
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_result_stage_if.slave  bus
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        flags_t           flags;
    } entry_t;

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    entry_t      mem_q [DEPTH];
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [15:0] op_count_q, op_count_d;

    logic             push_s, pop_s;
    logic             in_ready_s, out_valid_s;
    logic [WIDTH-1:0] calc_result_s;
    flags_t           calc_flags_s;

    nzcv_calc #(.WIDTH(WIDTH)) u_nzcv_calc (
        .s_i      (bus.s),
        .cout_i   (bus.cout),
        .a_msb_i  (bus.a_msb),
        .b_msb_i  (bus.b_msb),
        .result_o (calc_result_s),
        .flags_o  (calc_flags_s)
    );

    // Handshake status is decoded from the occupancy register only
    assign in_ready_s  = (count_q < FULL_CNT);
    assign out_valid_s = (count_q != 2'd0);
    assign push_s      = bus.in_valid && in_ready_s;
    assign pop_s       = out_valid_s && bus.out_ready;

    // Next-state for pointers, occupancy and the accepted-entry counter
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        op_count_d = op_count_q;
        count_d    = count_q;
        if (push_s) begin
            wr_ptr_d   = ~wr_ptr_q;
            op_count_d = op_count_q + 16'd1;
        end else begin
            wr_ptr_d   = wr_ptr_q;
            op_count_d = op_count_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            op_count_q <= 16'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            op_count_q <= op_count_d;
        end
    end

    // Entry storage; a push coinciding with reset is dropped
    always_ff @(posedge clk) begin
        if (rst_n && push_s) begin
            mem_q[wr_ptr_q] <= '{result: calc_result_s, flags: calc_flags_s};
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.op_count  = op_count_q;
    assign bus.result    = out_valid_s ? mem_q[rd_ptr_q].result : {WIDTH{1'b0}};
    assign bus.flags     = out_valid_s ? mem_q[rd_ptr_q].flags  : 4'b0000;

endmodule

// File: tb/tb_adder_result_stage.sv
// Scoreboard bench for adder_result_stage: expected entries are queued on push
// and compared against the head entry every cycle it is presented.
module tb_adder_result_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    adder_result_stage_if #(.WIDTH(32)) bus ();

    adder_result_stage #(.WIDTH(32), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [35:0] sb_q[$];
    logic [15:0] exp_op = 16'd0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] ref_entry(input logic [31:0] s, input logic c,
                                              input logic am, input logic bm);
        logic        v;
        logic [31:0] r;
        logic [3:0]  f;
        v = (am == bm) && (s[31] != am);
        r = s;
`ifdef RESULT_SAT_EN
        if (v) r = am ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        f = {r[31], (r == 32'h0000_0000), c, v};
        return {r, f};
    endfunction

    // One cycle: drive at negedge, check registered outputs, then advance the model.
    task automatic step(input logic iv, input logic [31:0] s, input logic c,
                        input logic am, input logic bm, input logic ordy);
        logic exp_rdy;
        logic exp_vld;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.s         = s;
        bus.cout      = c;
        bus.a_msb     = am;
        bus.b_msb     = bm;
        bus.out_ready = ordy;
        #1;
        exp_rdy = (sb_q.size() < 2);
        exp_vld = (sb_q.size() > 0);
        check_eq("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_rdy});
        check_eq("out_valid", {63'd0, bus.out_valid}, {63'd0, exp_vld});
        check_eq("op_count", {48'd0, bus.op_count}, {48'd0, exp_op});
        if (exp_vld) begin
            check_eq("result", {32'd0, bus.result}, {32'd0, sb_q[0][35:4]});
            check_eq("flags", {60'd0, bus.flags}, {60'd0, sb_q[0][3:0]});
        end else begin
            check_eq("result_idle", {32'd0, bus.result}, 64'd0);
            check_eq("flags_idle", {60'd0, bus.flags}, 64'd0);
        end
        if (exp_vld && ordy) void'(sb_q.pop_front());
        if (iv && exp_rdy) begin
            sb_q.push_back(ref_entry(s, c, am, bm));
            exp_op = exp_op + 16'd1;
        end
    endtask

    // One-cycle reset with a push and pop requested on the same edge.
    task automatic pulse_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.s         = 32'h1234_5678;
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        sb_q.delete();
        exp_op = 16'd0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.s         = 32'h0;
        bus.cout      = 1'b0;
        bus.a_msb     = 1'b0;
        bus.b_msb     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Negative sum with carry, pushed into an empty buffer
        step(1'b1, 32'hFFFF_FAFF, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("flags_1010", {60'd0, sb_q[0][3:0]}, {60'd0, 4'b1010});
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Small positive sum, then zero with carry
        step(1'b1, 32'h0000_001F, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Positive overflow and negative overflow
        step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h7FFF_FFFE, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Three pushes while stalled: third rejected, then drain in order
        step(1'b1, 32'h0000_00A1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_00B2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_00C3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Simultaneous push and pop at occupancy one
        step(1'b1, 32'h0000_1111, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_2222, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0000_3333, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset while full
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_reset();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Sustained random streaming past the op_count wrap
        for (int i = 0; i < 65540; i++) begin
            step(1'b1, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)),
                 1'($urandom_range(1)), 1'b1);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
